// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared state type and binary-to-Gray helper for the Gray code path
package gray_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned GRAY_MAX_W = 16;

    // Works at the widest legal width; callers zero-extend and slice back down.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_enc.sv
// rtl/gray_enc.sv - combinational WIDTH-bit binary-to-Gray encoder
import gray_pkg::*;

module gray_enc #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin_i,
    output logic [WIDTH-1:0] gray_o
);

    logic [GRAY_MAX_W-1:0] gray_full;
    logic                  unused_hi;

    assign gray_full = bin2gray(GRAY_MAX_W'(bin_i));
    assign gray_o    = gray_full[WIDTH-1:0];
    // Bits above WIDTH are always zero; fold them away explicitly.
    assign unused_hi = ^gray_full;

endmodule

// File: rtl/gray_seq_gen.sv
// rtl/gray_seq_gen.sv - loadable up/down binary sweep source with Gray output and valid/ready handshake
import gray_pkg::*;

module gray_seq_gen #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             wrap,
    output logic             done,
    output logic             busy
);

    localparam logic [WIDTH:0] CNT_LAST = (WIDTH+1)'((1 << WIDTH) - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH:0]   cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;

    logic             xfer;
    logic [WIDTH-1:0] bin_step;
    logic             at_wrap;

    assign xfer     = (state_q == RUN) && out_ready;
    assign bin_step = dir_q ? (bin_q - WIDTH'(1)) : (bin_q + WIDTH'(1));
    assign at_wrap  = dir_q ? (bin_q == '0) : (bin_q == '1);

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        wrap_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    bin_d = load_val;
                end
                if (start) begin
                    state_d = RUN;
                    dir_d   = dir;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (xfer) begin
                    bin_d  = bin_step;
                    cnt_d  = cnt_q + (WIDTH+1)'(1);
                    wrap_d = at_wrap;
                end
                // An abort wins over completion, so a stopped run never reports done.
                if (stop) begin
                    state_d = IDLE;
                end else if (xfer && (cnt_q == CNT_LAST)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    gray_enc #(.WIDTH(WIDTH)) u_gray_enc (
        .bin_i  (bin_q),
        .gray_o (gray_out)
    );

    assign out_valid = (state_q == RUN);
    assign busy      = (state_q == RUN);
    assign bin_out   = bin_q;
    assign wrap      = wrap_q;
    assign done      = done_q;

endmodule
